set_cmd_issuer: RTL and testbench

SET_CMD_ISSUER -- requirements
Module: set_cmd_issuer

---
 rtl/set_cmd_pkg.sv | 41 ++++
 rtl/set_cmd_fifo.sv | 62 ++++++
 rtl/set_cmd_issuer.sv | 163 ++++++++++++++++
 tb/tb_set_cmd_issuer.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/set_cmd_pkg.sv
// Shared types and constants for the SET command issuer and its FIFO.
package set_cmd_pkg;

  localparam int DEFAULT_DEPTH   = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  localparam int CENTRAL_W = 24;
  localparam int RADIUS_W  = 12;
  localparam int MODE_W    = 2;
  localparam int CAND_W    = 8;
  localparam int TAG_W     = 8;
  localparam int WAIT_W    = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // One queued command: 24 + 12 + 2 = 38 bits.
  typedef struct packed {
    logic [CENTRAL_W-1:0] central;
    logic [RADIUS_W-1:0]  radius;
    logic [MODE_W-1:0]    mode;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  function automatic cmd_t make_cmd(
    input logic [CENTRAL_W-1:0] central,
    input logic [RADIUS_W-1:0]  radius,
    input logic [MODE_W-1:0]    mode
  );
    cmd_t c;
    c.central = central;
    c.radius  = radius;
    c.mode    = mode;
    return c;
  endfunction

endpackage

// File: rtl/set_cmd_fifo.sv
// Command FIFO: DEPTH entries (power of two), registered occupancy count,
// head presented combinationally on rdata. Push at full and pop at empty are dropped.
module set_cmd_fifo
  import set_cmd_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  cmd_t                     wdata,
  output cmd_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_COUNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage array needs no reset: reset empties the FIFO through the pointers.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

endmodule

// File: rtl/set_cmd_issuer.sv
// Buffers SET commands, issues them one at a time to the SET engine,
// waits for each result (with a timeout) and presents it tagged.
module set_cmd_issuer
  import set_cmd_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CENTRAL_W-1:0] cmd_central,
  input  logic [RADIUS_W-1:0]  cmd_radius,
  input  logic [MODE_W-1:0]    cmd_mode,
  input  logic                 set_busy,
  input  logic                 set_valid,
  input  logic [CAND_W-1:0]    set_candidate,
  output logic                 set_en,
  output logic [CENTRAL_W-1:0] set_central,
  output logic [RADIUS_W-1:0]  set_radius,
  output logic [MODE_W-1:0]    set_mode,
  output logic                 res_valid,
  output logic [CAND_W-1:0]    res_candidate,
  output logic [TAG_W-1:0]     res_tag,
  output logic                 timeout_err,
  output logic                 idle
);

  localparam int               CW        = $clog2(DEPTH) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            next_state;
  cmd_t              push_cmd;
  cmd_t              head_cmd;
  logic              push;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [TAG_W-1:0]  tag_cnt;
  logic [TAG_W-1:0]  cur_tag;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_last;
  logic              start_issue;

  assign push_cmd  = make_cmd(cmd_central, cmd_radius, cmd_mode);
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == ST_ISSUE);
  assign idle      = fifo_empty && (state == ST_IDLE);
  assign wait_last = (wait_cnt == WAIT_LAST);

  set_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_cmd),
    .rdata (head_cmd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start_issue marks the IDLE->ISSUE transition.
  always_comb begin
    next_state  = state;
    start_issue = 1'b0;
    case (state)
      ST_IDLE: begin
        if ((fifo_count != '0) && !set_busy) begin
          next_state  = ST_ISSUE;
          start_issue = 1'b1;
        end
      end
      ST_ISSUE: begin
        next_state = ST_WAIT;
      end
      ST_WAIT: begin
        if (set_valid || wait_last) begin
          next_state = ST_IDLE;
        end
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Registered drive to the SET engine: pulse during ISSUE, payload held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      set_en      <= 1'b0;
      set_central <= '0;
      set_radius  <= '0;
      set_mode    <= '0;
    end else begin
      set_en <= start_issue;
      if (start_issue) begin
        set_central <= head_cmd.central;
        set_radius  <= head_cmd.radius;
        set_mode    <= head_cmd.mode;
      end
    end
  end

  // Tag bookkeeping: the issued command keeps its tag until its result comes back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_cnt <= '0;
      cur_tag <= '0;
    end else if (state == ST_ISSUE) begin
      cur_tag <= tag_cnt;
      tag_cnt <= tag_cnt + 1'b1;
    end
  end

  // Wait-cycle counter runs from 0 while staying in WAIT, cleared otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && (next_state == ST_WAIT)) begin
      wait_cnt <= wait_cnt + 1'b1;
    end else begin
      wait_cnt <= '0;
    end
  end

  // Result capture and sticky timeout; a result on the last wait cycle wins over the error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      timeout_err   <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      if (state == ST_WAIT) begin
        if (set_valid) begin
          res_valid     <= 1'b1;
          res_candidate <= set_candidate;
          res_tag       <= cur_tag;
        end else if (wait_last) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_set_cmd_issuer.sv
// Scoreboard bench for set_cmd_issuer: stimulus pushes expected issues/results
// into queues, a negedge monitor pops and compares. A second instance with
// TIMEOUT=16 exercises the wait-timeout boundary.
module tb_set_cmd_issuer;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [23:0] cmd_central;
  logic [11:0] cmd_radius;
  logic [1:0]  cmd_mode;
  logic        set_busy;
  logic        set_valid;
  logic [7:0]  set_candidate;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        res_valid;
  logic [7:0]  res_candidate;
  logic [7:0]  res_tag;
  logic        timeout_err;
  logic        idle;

  logic        to_cmd_valid;
  logic        to_cmd_ready;
  logic        to_set_valid;
  logic [7:0]  to_set_candidate;
  logic        to_set_en;
  logic [23:0] to_set_central;
  logic [11:0] to_set_radius;
  logic [1:0]  to_set_mode;
  logic        to_res_valid;
  logic [7:0]  to_res_candidate;
  logic [7:0]  to_res_tag;
  logic        to_timeout_err;
  logic        to_idle;

  int          total = 0;
  int          bad   = 0;

  logic [37:0] exp_issue [$];
  logic [15:0] exp_res   [$];
  logic [7:0]  cand_q    [$];
  logic [7:0]  exp_tag;
  int          resp_delay;
  bit          resp_on;
  int          issue_cnt = 0;
  int          res_cnt   = 0;
  logic [7:0]  last_res_tag = 8'h00;
  int          stray_req  = 0;
  int          stray_done = 0;

  set_cmd_issuer #(
    .DEPTH   (4),
    .TIMEOUT (1024)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_central   (cmd_central),
    .cmd_radius    (cmd_radius),
    .cmd_mode      (cmd_mode),
    .set_busy      (set_busy),
    .set_valid     (set_valid),
    .set_candidate (set_candidate),
    .set_en        (set_en),
    .set_central   (set_central),
    .set_radius    (set_radius),
    .set_mode      (set_mode),
    .res_valid     (res_valid),
    .res_candidate (res_candidate),
    .res_tag       (res_tag),
    .timeout_err   (timeout_err),
    .idle          (idle)
  );

  set_cmd_issuer #(
    .DEPTH   (4),
    .TIMEOUT (16)
  ) u_to (
    .clk           (clk),
    .rst           (rst),
    .cmd_valid     (to_cmd_valid),
    .cmd_ready     (to_cmd_ready),
    .cmd_central   (cmd_central),
    .cmd_radius    (cmd_radius),
    .cmd_mode      (cmd_mode),
    .set_busy      (set_busy),
    .set_valid     (to_set_valid),
    .set_candidate (to_set_candidate),
    .set_en        (to_set_en),
    .set_central   (to_set_central),
    .set_radius    (to_set_radius),
    .set_mode      (to_set_mode),
    .res_valid     (to_res_valid),
    .res_candidate (to_res_candidate),
    .res_tag       (to_res_tag),
    .timeout_err   (to_timeout_err),
    .idle          (to_idle)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait is never satisfied
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: compares every set_en pulse and every res_valid against the scoreboard
  initial begin
    logic [37:0] ei;
    logic [15:0] er;
    bit          outstanding;
    bit          prev_en;
    outstanding = 1'b0;
    prev_en     = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        exp_issue.delete();
        exp_res.delete();
        outstanding = 1'b0;
        prev_en     = 1'b0;
      end else begin
        if (set_en) begin
          issue_cnt++;
          total++;
          if (outstanding || prev_en) begin
            bad++;
            $display("[TB] FAIL set_en_overlap: got set_en=1 required 0 while a command is in flight");
          end
          if (exp_issue.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_set_en: got set_en=1 required no issue (central=0x%0h)", set_central);
          end else begin
            ei = exp_issue.pop_front();
            check_output("issue_cmd", 64'({set_central, set_radius, set_mode}), 64'(ei));
          end
          outstanding = 1'b1;
        end
        prev_en = set_en;
        if (res_valid) begin
          res_cnt++;
          last_res_tag = res_tag;
          outstanding  = 1'b0;
          if (exp_res.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_res_valid: got res_valid=1 tag=0x%0h required 0", res_tag);
          end else begin
            er = exp_res.pop_front();
            check_output("res_candidate", 64'(res_candidate), 64'(er[15:8]));
            check_output("res_tag", 64'(res_tag), 64'(er[7:0]));
          end
        end
      end
    end
  end

  // SET engine model for the main instance: answers each set_en after resp_delay cycles
  initial begin
    bit         pending;
    int         cd;
    logic [7:0] pcand;
    pending       = 1'b0;
    cd            = 0;
    pcand         = 8'h00;
    set_valid     = 1'b0;
    set_candidate = 8'h00;
    forever begin
      @(negedge clk);
      set_valid = 1'b0;
      if (!rst) begin
        pending = 1'b0;
        cand_q.delete();
      end else begin
        if (stray_req != stray_done) begin
          stray_done    = stray_req;
          set_valid     = 1'b1;
          set_candidate = 8'hEE;
        end
        if (pending) begin
          cd--;
          if (cd <= 0) begin
            set_valid     = 1'b1;
            set_candidate = pcand;
            pending       = 1'b0;
          end
        end
        if (set_en && resp_on) begin
          pending = 1'b1;
          cd      = resp_delay;
          pcand   = (cand_q.size() != 0) ? cand_q.pop_front() : 8'h00;
        end
      end
    end
  end

  // Push one command into the main instance and record what it must produce
  task automatic apply_stimulus(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m,
                                input bit answer, input logic [7:0] cand);
    int n;
    cmd_central = c;
    cmd_radius  = r;
    cmd_mode    = m;
    cmd_valid   = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      total++;
      bad++;
      $display("[TB] FAIL push_wait: got cmd_ready=%b required 1 within 400 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    exp_issue.push_back({c, r, m});
    if (answer) begin
      exp_res.push_back({cand, exp_tag});
      cand_q.push_back(cand);
    end
    exp_tag = exp_tag + 8'd1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic to_push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    cmd_central  = c;
    cmd_radius   = r;
    cmd_mode     = m;
    to_cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    to_cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound, input string name);
    int n;
    n = 0;
    while ((exp_issue.size() != 0 || exp_res.size() != 0) && n < bound) begin
      @(posedge clk);
      n++;
    end
    check_output(name, 64'(exp_issue.size() + exp_res.size()), 64'(0));
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic to_wait_en(input string name);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (to_set_en) found = 1'b1;
    end
    check_output(name, 64'(found), 64'(1));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst     = 1'b0;
    exp_tag = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int base_i;
    int base_r;
    int n;
    bit saw_res;

    rst              = 1'b0;
    cmd_valid        = 1'b0;
    cmd_central      = 24'h0;
    cmd_radius       = 12'h0;
    cmd_mode         = 2'd0;
    set_busy         = 1'b0;
    to_cmd_valid     = 1'b0;
    to_set_valid     = 1'b0;
    to_set_candidate = 8'h00;
    exp_tag          = 8'h00;
    resp_delay       = 20;
    resp_on          = 1'b1;

    // Reset state
    #12;
    check_output("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    check_output("rst_idle", 64'(idle), 64'(1));
    check_output("rst_set_en", 64'(set_en), 64'(0));
    check_output("rst_set_drive", 64'({set_central, set_radius, set_mode}), 64'(0));
    check_output("rst_res", 64'({res_valid, res_candidate, res_tag}), 64'(0));
    check_output("rst_timeout_err", 64'(timeout_err), 64'(0));
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single command, answer after 20 cycles, latency E1-E2
    $display("[TB] single command");
    base_r = res_cnt;
    apply_stimulus(24'h448800, 12'h330, 2'd1, 1'b1, 8'h15);
    @(negedge clk);
    check_output("latency_e0_e1", 64'(set_en), 64'(0));
    @(negedge clk);
    check_output("latency_e1_e2", 64'(set_en), 64'(1));
    check_output("busy_not_idle", 64'(idle), 64'(0));
    wait_drain(100, "drain_single");
    check_output("single_res_count", 64'(res_cnt - base_r), 64'(1));
    check_output("hold_set_central", 64'(set_central), 64'(24'h448800));
    check_output("hold_set_en_low", 64'(set_en), 64'(0));

    // set_valid while idle is ignored
    $display("[TB] stray set_valid");
    base_r = res_cnt;
    stray_req++;
    repeat (6) @(posedge clk);
    #1;
    check_output("stray_no_result", 64'(res_cnt - base_r), 64'(0));
    check_output("stray_idle", 64'(idle), 64'(1));

    // Three commands, answers after 5 cycles, tags 0,1,2
    $display("[TB] three commands");
    do_reset();
    check_output("reset_clears_drive", 64'({set_central, set_radius, set_mode}), 64'(0));
    resp_delay = 5;
    base_r = res_cnt;
    apply_stimulus(24'h000001, 12'h001, 2'd0, 1'b1, 8'h31);
    apply_stimulus(24'h123456, 12'hABC, 2'd2, 1'b1, 8'h32);
    apply_stimulus(24'hFFFFFF, 12'hFFF, 2'd3, 1'b1, 8'h33);
    wait_drain(200, "drain_three");
    check_output("three_res_count", 64'(res_cnt - base_r), 64'(3));
    check_output("three_last_tag", 64'(last_res_tag), 64'(2));

    // Fill with set_busy high: 5th push refused, nothing issued
    $display("[TB] fill while busy");
    do_reset();
    set_busy   = 1'b1;
    resp_delay = 3;
    base_i = issue_cnt;
    apply_stimulus(24'h100001, 12'h011, 2'd1, 1'b1, 8'h41);
    apply_stimulus(24'h200002, 12'h022, 2'd2, 1'b1, 8'h42);
    apply_stimulus(24'h300003, 12'h033, 2'd3, 1'b1, 8'h43);
    apply_stimulus(24'h400004, 12'h044, 2'd0, 1'b1, 8'h44);
    check_output("ready_after_4", 64'(cmd_ready), 64'(0));
    cmd_central = 24'hBADBAD;
    cmd_radius  = 12'h555;
    cmd_mode    = 2'd1;
    cmd_valid   = 1'b1;
    repeat (3) begin
      check_output("push5_refused", 64'(cmd_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_output("no_issue_busy", 64'(issue_cnt - base_i), 64'(0));
    set_busy = 1'b0;
    wait_drain(300, "drain_full");
    check_output("full_issue_count", 64'(issue_cnt - base_i), 64'(4));
    check_output("full_idle", 64'(idle), 64'(1));
    check_output("full_ready", 64'(cmd_ready), 64'(1));

    // 257 commands: tag wraps back to 0
    $display("[TB] tag wrap");
    do_reset();
    resp_delay = 1;
    base_r = res_cnt;
    for (int i = 0; i < 257; i++) begin
      apply_stimulus(24'(i * 3), 12'(i), 2'(i), 1'b1, 8'(i) ^ 8'h5A);
    end
    wait_drain(3000, "drain_wrap");
    check_output("wrap_res_count", 64'(res_cnt - base_r), 64'(257));
    check_output("wrap_last_tag", 64'(last_res_tag), 64'(0));

    // Reset in WAIT with two commands queued
    $display("[TB] reset mid-operation");
    do_reset();
    resp_on = 1'b0;
    base_i  = issue_cnt;
    apply_stimulus(24'h0A0A0A, 12'h101, 2'd1, 1'b0, 8'h00);
    apply_stimulus(24'h0B0B0B, 12'h202, 2'd2, 1'b0, 8'h00);
    apply_stimulus(24'h0C0C0C, 12'h303, 2'd3, 1'b0, 8'h00);
    n = 0;
    while (issue_cnt == base_i && n < 50) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check_output("first_issued", 64'(issue_cnt - base_i), 64'(1));
    check_output("wait_not_idle", 64'(idle), 64'(0));
    rst     = 1'b0;
    exp_tag = 8'h00;
    #1;
    check_output("midrst_set_en", 64'(set_en), 64'(0));
    check_output("midrst_drive", 64'({set_central, set_radius, set_mode}), 64'(0));
    check_output("midrst_res", 64'({res_valid, res_candidate, res_tag}), 64'(0));
    check_output("midrst_err", 64'(timeout_err), 64'(0));
    check_output("midrst_ready", 64'(cmd_ready), 64'(1));
    check_output("midrst_idle", 64'(idle), 64'(1));
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    base_i = issue_cnt;
    repeat (12) @(posedge clk);
    #1;
    check_output("no_issue_after_rst", 64'(issue_cnt - base_i), 64'(0));
    check_output("idle_after_rst", 64'(idle), 64'(1));
    resp_on    = 1'b1;
    resp_delay = 2;
    apply_stimulus(24'h0D0D0D, 12'h404, 2'd0, 1'b1, 8'h66);
    wait_drain(100, "drain_after_rst");
    check_output("tag_after_rst", 64'(last_res_tag), 64'(0));

    // Timeout instance (TIMEOUT=16): result on last wait cycle, then a real timeout
    $display("[TB] timeout instance");
    do_reset();
    check_output("to_ready", 64'(to_cmd_ready), 64'(1));
    set_busy = 1'b1;
    to_push(24'hA00001, 12'h0A1, 2'd1);
    to_push(24'hB00002, 12'h0B2, 2'd2);
    to_push(24'hC00003, 12'h0C3, 2'd3);
    set_busy = 1'b0;
    to_wait_en("to_issue_a");
    check_output("to_drive_a", 64'({to_set_central, to_set_radius, to_set_mode}),
                 64'({24'hA00001, 12'h0A1, 2'd1}));
    repeat (15) @(negedge clk);
    @(negedge clk);
    to_set_valid     = 1'b1;
    to_set_candidate = 8'hA7;
    @(negedge clk);
    to_set_valid = 1'b0;
    check_output("to_edge_res_valid", 64'(to_res_valid), 64'(1));
    check_output("to_edge_res", 64'({to_res_candidate, to_res_tag}), 64'({8'hA7, 8'h00}));
    check_output("to_edge_no_err", 64'(to_timeout_err), 64'(0));
    to_wait_en("to_issue_b");
    saw_res = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (to_res_valid) saw_res = 1'b1;
      if (k == 16) check_output("to_err_before", 64'(to_timeout_err), 64'(0));
    end
    @(negedge clk);
    if (to_res_valid) saw_res = 1'b1;
    check_output("to_err_after", 64'(to_timeout_err), 64'(1));
    check_output("to_no_res", 64'(saw_res), 64'(0));
    to_wait_en("to_issue_c");
    check_output("to_drive_c", 64'({to_set_central, to_set_radius, to_set_mode}),
                 64'({24'hC00003, 12'h0C3, 2'd3}));
    check_output("to_not_idle", 64'(to_idle), 64'(0));
    repeat (20) @(negedge clk);
    check_output("to_err_sticky", 64'(to_timeout_err), 64'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
